inst_fetch: RTL and testbench

Instruction fetch sequencer that drives the instruction memory from the requesting side. It generates halfword-aligned 16-bit byte addresses and absorbs the memory's fixed one-cycle registered read latency. It presents fetched instructions with their PC to the decode stage over a valid/ready handshake, and supports branch/jump redirects. A one-entry skid buffer keeps back-pressure lossless, because the memory has no enable and re-reads its address on every clock.

---
 rtl/inst_fetch.sv | 90 +++++++++
 tb/tb_inst_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: drives a 1-cycle registered instruction memory
// and hands words to decode over valid/ready, with a one-entry skid buffer.
module inst_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_inst,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_inst,
   output logic [15:0] out_pc
);

   logic [15:0] fetch_pc;
   logic [15:0] req_pc;
   logic        req_valid;
   logic        skid_valid;
   logic [15:0] skid_inst;
   logic [15:0] skid_pc;

   logic [15:0] tgt_pc;
   logic        do_redir;
   logic        do_fill;
   logic        do_drain;

   assign tgt_pc   = redirect_pc & 16'hFFFE;
   assign do_redir = redirect_valid;
   assign do_fill  = ~redirect_valid & ~skid_valid;
   assign do_drain = ~redirect_valid & skid_valid;

   // Address select: redirect target, reissue of the held word, or next sequential
   always_comb begin
      mem_addr = fetch_pc;
      unique case (1'b1)
         do_redir: mem_addr = tgt_pc;
         do_drain: mem_addr = req_pc;
         do_fill:  mem_addr = fetch_pc;
      endcase
   end

   // Output mux: skid word has priority over the word arriving from memory
   always_comb begin
      out_valid = (skid_valid | req_valid) & ~redirect_valid;
      out_inst  = mem_inst;
      out_pc    = req_pc;
      if (skid_valid) begin
         out_inst = skid_inst;
         out_pc   = skid_pc;
      end
   end

   // Sequencing state: memory request tracking, fetch pointer and skid buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc   <= RESET_PC;
         req_pc     <= 16'h0000;
         req_valid  <= 1'b0;
         skid_valid <= 1'b0;
         skid_inst  <= 16'h0000;
         skid_pc    <= 16'h0000;
      end else begin
         req_pc    <= mem_addr;
         req_valid <= 1'b1;
         unique case (1'b1)
            do_redir: begin
               fetch_pc   <= tgt_pc + 16'd2;
               skid_valid <= 1'b0;
            end
            do_fill: begin
               fetch_pc <= fetch_pc + 16'd2;
               if (req_valid && !out_ready) begin
                  skid_valid <= 1'b1;
                  skid_inst  <= mem_inst;
                  skid_pc    <= req_pc;
               end
            end
            do_drain: begin
               if (out_ready) begin
                  skid_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural stream model plus directed literal
// checks, then randomized ready/redirect/reset traffic.
module tb_inst_fetch;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_inst;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_inst;
   logic [15:0] out_pc;

   int vectors;
   int miscompares;

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_addr(mem_addr),
      .mem_inst(mem_inst),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_inst(out_inst),
      .out_pc(out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] word(input logic [15:0] a);
      return 16'h1000 + {1'b0, a[15:1]};
   endfunction

   // Memory: registered read, one cycle latency, no enable
   logic [15:0] addr_q;
   always @(negedge clk) addr_q <= mem_addr;
   always @(posedge clk) mem_inst <= word(addr_q);

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the next program-order pc decode must see, and whether any
   // clock edge has happened since reset released.
   logic [15:0] exp_pc;
   logic        started;
   logic [15:0] m_tgt;
   logic [15:0] m_nxt;
   logic        m_v;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk1("rst_valid", out_valid, 1'b0);
         chk("rst_pc", out_pc, 16'h0000);
         chk("rst_addr", mem_addr, RESET_PC);
         chk("rst_inst", out_inst, mem_inst);
         exp_pc  = RESET_PC;
         started = 1'b0;
      end else begin
         m_tgt = {redirect_pc[15:1], 1'b0};
         m_nxt = exp_pc + 16'd2;
         m_v   = started && !redirect_valid;
         chk1("m_valid", out_valid, m_v);
         if (redirect_valid)
            chk("m_addr_redir", mem_addr, m_tgt);
         else if (started)
            chk("m_addr_next", mem_addr, m_nxt);
         else
            chk("m_addr_first", mem_addr, exp_pc);
         if (m_v) begin
            chk("m_pc", out_pc, exp_pc);
            chk("m_inst", out_inst, word(exp_pc));
         end
         if (redirect_valid)
            exp_pc = m_tgt;
         else if (m_v && out_ready)
            exp_pc = m_nxt;
         started = 1'b1;
      end
   end

   task automatic step(input logic rdy, input logic rv,
                       input logic [15:0] rpc);
      @(posedge clk);
      #1;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic lit(input string name, input logic v,
                      input logic [15:0] pc, input logic [15:0] inst);
      chk1({name, "_v"}, out_valid, v);
      if (v) begin
         chk({name, "_pc"}, out_pc, pc);
         chk({name, "_inst"}, out_inst, inst);
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      lit("c0", 1'b0, 16'h0, 16'h0);
      chk("c0_addr", mem_addr, 16'h0000);
      step(1'b1, 1'b0, 16'h0);
      lit("c1", 1'b1, 16'h0000, 16'h1000);
      step(1'b1, 1'b0, 16'h0);
      lit("c2", 1'b1, 16'h0002, 16'h1001);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 16'h0);
         lit("hold", 1'b1, 16'h0004, 16'h1002);
         chk("hold_addr", mem_addr, 16'h0006);
      end
      step(1'b1, 1'b0, 16'h0);
      lit("rel0", 1'b1, 16'h0004, 16'h1002);
      step(1'b1, 1'b0, 16'h0);
      lit("rel1", 1'b1, 16'h0006, 16'h1003);
      step(1'b1, 1'b1, 16'h0041);
      lit("redir", 1'b0, 16'h0, 16'h0);
      chk("redir_addr", mem_addr, 16'h0040);
      step(1'b1, 1'b0, 16'h0);
      lit("tgt0", 1'b1, 16'h0040, 16'h1020);
      step(1'b1, 1'b0, 16'h0);
      lit("tgt1", 1'b1, 16'h0042, 16'h1021);
      step(1'b0, 1'b0, 16'h0);
      lit("stall0", 1'b1, 16'h0044, 16'h1022);
      step(1'b0, 1'b0, 16'h0);
      lit("stall1", 1'b1, 16'h0044, 16'h1022);
      step(1'b0, 1'b1, 16'h0100);
      lit("skid_redir", 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      lit("skid_tgt", 1'b1, 16'h0100, 16'h1080);
      step(1'b1, 1'b1, 16'hFFFC);
      lit("wrap_redir", 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      lit("wrap0", 1'b1, 16'hFFFC, 16'h8FFE);
      step(1'b1, 1'b0, 16'h0);
      lit("wrap1", 1'b1, 16'hFFFE, 16'h8FFF);
      step(1'b1, 1'b0, 16'h0);
      lit("wrap2", 1'b1, 16'h0000, 16'h1000);
      step(1'b1, 1'b0, 16'h0);
      lit("wrap3", 1'b1, 16'h0002, 16'h1001);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0);
      lit("pre_rst", 1'b1, 16'h0004, 16'h1002);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      lit("mid_rst", 1'b0, 16'h0, 16'h0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      lit("rs0", 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      lit("rs1", 1'b1, 16'h0000, 16'h1000);
      step(1'b1, 1'b0, 16'h0);
      lit("rs2", 1'b1, 16'h0002, 16'h1001);

      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rst_n          = 1'b1;
            redirect_valid = 1'b0;
            out_ready      = ($urandom_range(0, 9) < 7);
         end else if ($urandom_range(0, 199) == 0) begin
            rst_n          = 1'b0;
            redirect_valid = 1'b0;
         end else begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
               redirect_pc = 16'hFFF8 | 16'($urandom_range(0, 7));
            else
               redirect_pc = 16'($urandom_range(0, 65535));
         end
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
